// File: rtl/seq_lock_ctrl.sv
// Code-lock controller: supervises an external 1-4-6-9 sequence detector and runs the
// ARMED / OPEN / LOCKED modes with a shared 8-bit window timer and a failed-attempt counter.
module seq_lock_ctrl #(
    parameter int UNLOCK_CYCLES  = 8,
    parameter int LOCKOUT_CYCLES = 16,
    parameter int MAX_FAILS      = 3
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       digit_valid_i,
    input  logic [3:0] data_i,
    input  logic [1:0] NextState_i,
    output logic [1:0] CurrentState_o,
    output logic       unlock_o,
    output logic       alarm_o,
    output logic [1:0] fail_cnt_o
);

    typedef enum logic [1:0] {
        ARMED  = 2'b00,
        OPEN   = 2'b01,
        LOCKED = 2'b10
    } mode_t;

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S3 = 2'b11;

    localparam logic [7:0] UNLOCK_LOAD  = 8'(UNLOCK_CYCLES);
    localparam logic [7:0] LOCKOUT_LOAD = 8'(LOCKOUT_CYCLES);
    localparam logic [2:0] MAX_FAILS_W  = 3'(MAX_FAILS);

    mode_t      mode_q, mode_d;
    logic [7:0] timer_q, timer_d;
    logic [1:0] state_q, state_d;
    logic       unlock_q, unlock_d;
    logic       alarm_q, alarm_d;
    logic [1:0] fail_cnt_q, fail_cnt_d;

    logic       accept;
    logic       match;
    logic       fail;
    logic [2:0] fail_cnt_inc;

    // Digits only count while ARMED; a match is never a fail.
    always_comb begin
        accept       = digit_valid_i && (mode_q == ARMED);
        match        = accept && (state_q == S3) && (data_i == 4'd9);
        fail         = accept && !match && (state_q != S0) && (NextState_i == S0);
        fail_cnt_inc = {1'b0, fail_cnt_q} + 3'd1;
    end

    always_comb begin
        mode_d     = mode_q;
        timer_d    = timer_q;
        state_d    = state_q;
        unlock_d   = unlock_q;
        alarm_d    = alarm_q;
        fail_cnt_d = fail_cnt_q;

        unique case (mode_q)
            ARMED: begin
                if (match) begin
                    mode_d     = OPEN;
                    state_d    = S0;
                    fail_cnt_d = 2'd0;
                    timer_d    = UNLOCK_LOAD;
                    unlock_d   = 1'b1;
                end else if (fail && (fail_cnt_inc >= MAX_FAILS_W)) begin
                    mode_d     = LOCKED;
                    state_d    = S0;
                    fail_cnt_d = MAX_FAILS_W[1:0];
                    timer_d    = LOCKOUT_LOAD;
                    alarm_d    = 1'b1;
                end else if (accept) begin
                    state_d = NextState_i;
                    if (fail) begin
                        fail_cnt_d = fail_cnt_inc[1:0];
                    end
                end
            end

            // Timer value 1 marks the last window cycle; a digit on that exit edge is dropped.
            OPEN: begin
                timer_d = timer_q - 8'd1;
                if (timer_q <= 8'd1) begin
                    mode_d   = ARMED;
                    unlock_d = 1'b0;
                end
            end

            LOCKED: begin
                timer_d = timer_q - 8'd1;
                if (timer_q <= 8'd1) begin
                    mode_d     = ARMED;
                    alarm_d    = 1'b0;
                    fail_cnt_d = 2'd0;
                end
            end

            default: begin
                mode_d   = ARMED;
                timer_d  = 8'd0;
                state_d  = S0;
                unlock_d = 1'b0;
                alarm_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mode_q     <= ARMED;
            timer_q    <= 8'd0;
            state_q    <= S0;
            unlock_q   <= 1'b0;
            alarm_q    <= 1'b0;
            fail_cnt_q <= 2'd0;
        end else begin
            mode_q     <= mode_d;
            timer_q    <= timer_d;
            state_q    <= state_d;
            unlock_q   <= unlock_d;
            alarm_q    <= alarm_d;
            fail_cnt_q <= fail_cnt_d;
        end
    end

    assign CurrentState_o = state_q;
    assign unlock_o       = unlock_q;
    assign alarm_o        = alarm_q;
    assign fail_cnt_o     = fail_cnt_q;

endmodule
